// File: rtl/motor_pkg.sv
// Shared definitions for the motor soft-drive block: FSM state encoding and default sizing.
package motor_pkg;

   typedef enum logic [1:0] {
      ST_STOPPED   = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RUNNING   = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } motor_state_e;

   localparam int unsigned DUTY_W_DEF   = 8;
   localparam int unsigned PWM_DIV_DEF  = 10;
   localparam int unsigned RAMP_DIV_DEF = 50000;

   // Counter width for a modulo-n prescaler; never below one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/motor_soft_drive_if.sv
// Control-side bundle of motor_soft_drive: run request in, PWM gate and status out.
// MOTOR_SOFT_ESTOP_EN adds the estop request line.
interface motor_soft_drive_if
   import motor_pkg::*;
#(
   parameter int unsigned DUTY_W = DUTY_W_DEF
) ();

   logic              motor_on;
`ifdef MOTOR_SOFT_ESTOP_EN
   logic              estop;
`endif
   logic              pwm_out;
   logic [DUTY_W-1:0] duty;
   logic              ramping;
   logic              at_speed;

   modport master (
`ifdef MOTOR_SOFT_ESTOP_EN
      output estop,
`endif
      output motor_on,
      input  pwm_out,
      input  duty,
      input  ramping,
      input  at_speed
   );

   modport slave (
`ifdef MOTOR_SOFT_ESTOP_EN
      input  estop,
`endif
      input  motor_on,
      output pwm_out,
      output duty,
      output ramping,
      output at_speed
   );

endinterface

// File: rtl/pwm_gen.sv
// PWM generator: prescaled period counter, period-boundary shadow of the duty, registered compare.
module pwm_gen
   import motor_pkg::*;
#(
   parameter int unsigned DUTY_W  = DUTY_W_DEF,
   parameter int unsigned PWM_DIV = PWM_DIV_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DUTY_W-1:0] duty_i,
   input  logic              clear_i,
   output logic              pwm_o
);

   localparam int unsigned DUTY_MAX = (1 << DUTY_W) - 1;
   localparam int unsigned PDIV_W   = cnt_w(PWM_DIV);
   localparam logic [DUTY_W-1:0] PCNT_LAST = DUTY_W'(DUTY_MAX - 1);
   localparam logic [PDIV_W-1:0] PDIV_LAST = PDIV_W'(PWM_DIV - 1);

   logic [PDIV_W-1:0] pdiv_q;
   logic [DUTY_W-1:0] pcnt_q;
   logic [DUTY_W-1:0] shadow_q;
   logic              pwm_q;
   logic              step_c;
   logic              wrap_c;

   assign step_c = (pdiv_q == PDIV_LAST);
   assign wrap_c = step_c && (pcnt_q == PCNT_LAST);

   // Counter runs 0..DUTY_MAX-1 so a shadow of DUTY_MAX keeps the compare true all period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pdiv_q   <= '0;
         pcnt_q   <= '0;
         shadow_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         pdiv_q <= step_c ? '0 : pdiv_q + PDIV_W'(1);
         if (step_c) begin
            pcnt_q <= wrap_c ? '0 : pcnt_q + DUTY_W'(1);
         end
         if (clear_i) begin
            shadow_q <= '0;
         end else if (wrap_c) begin
            shadow_q <= duty_i;
         end
         pwm_q <= clear_i ? 1'b0 : (pcnt_q < shadow_q);
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_soft_drive.sv
// Soft-start/soft-stop motor drive: ramps duty linearly on motor_on and feeds pwm_gen.
// MOTOR_SOFT_ESTOP_EN adds a latched emergency stop that bypasses the ramps.
module motor_soft_drive
   import motor_pkg::*;
#(
   parameter int unsigned DUTY_W   = DUTY_W_DEF,
   parameter int unsigned PWM_DIV  = PWM_DIV_DEF,
   parameter int unsigned RAMP_DIV = RAMP_DIV_DEF
) (
   input  logic               clk,
   input  logic               reset,
   motor_soft_drive_if.slave  bus
);

   localparam int unsigned DUTY_MAX = (1 << DUTY_W) - 1;
   localparam int unsigned RDIV_W   = cnt_w(RAMP_DIV);
   localparam logic [DUTY_W-1:0] DMAX_V    = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] DONE_UP_V = DUTY_W'(DUTY_MAX - 1);
   localparam logic [DUTY_W-1:0] ONE_V     = DUTY_W'(1);
   localparam logic [RDIV_W-1:0] RDIV_LAST = RDIV_W'(RAMP_DIV - 1);

   motor_state_e      state_q;
   logic [DUTY_W-1:0] duty_q;
   logic [RDIV_W-1:0] rcnt_q;
   logic              ramping_q;
   logic              at_speed_q;
   logic              tick_c;
   logic              kill_c;
   logic              start_ok_c;

`ifdef MOTOR_SOFT_ESTOP_EN
   logic latched_q;

   // Latch holds until estop and motor_on are both low in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latched_q <= 1'b0;
      end else if (bus.estop) begin
         latched_q <= 1'b1;
      end else if (!bus.motor_on) begin
         latched_q <= 1'b0;
      end
   end

   assign kill_c     = bus.estop;
   assign start_ok_c = !latched_q;
`else
   assign kill_c     = 1'b0;
   assign start_ok_c = 1'b1;
`endif

   assign tick_c = (rcnt_q == RDIV_LAST);

   // Every transition clears the ramp prescaler; a motor_on change beats a same-cycle tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_STOPPED;
         duty_q     <= '0;
         rcnt_q     <= '0;
         ramping_q  <= 1'b0;
         at_speed_q <= 1'b0;
      end else if (kill_c) begin
         state_q    <= ST_STOPPED;
         duty_q     <= '0;
         rcnt_q     <= '0;
         ramping_q  <= 1'b0;
         at_speed_q <= 1'b0;
      end else begin
         case (state_q)
            ST_STOPPED: begin
               duty_q <= '0;
               rcnt_q <= '0;
               if (bus.motor_on && start_ok_c) begin
                  state_q   <= ST_RAMP_UP;
                  ramping_q <= 1'b1;
               end
            end
            ST_RAMP_UP: begin
               if (!bus.motor_on) begin
                  state_q <= ST_RAMP_DOWN;
                  rcnt_q  <= '0;
               end else if (tick_c) begin
                  rcnt_q <= '0;
                  if (duty_q != DMAX_V) begin
                     duty_q <= duty_q + ONE_V;
                  end
                  if (duty_q >= DONE_UP_V) begin
                     state_q    <= ST_RUNNING;
                     ramping_q  <= 1'b0;
                     at_speed_q <= 1'b1;
                  end
               end else begin
                  rcnt_q <= rcnt_q + RDIV_W'(1);
               end
            end
            ST_RUNNING: begin
               duty_q <= DMAX_V;
               rcnt_q <= '0;
               if (!bus.motor_on) begin
                  state_q    <= ST_RAMP_DOWN;
                  ramping_q  <= 1'b1;
                  at_speed_q <= 1'b0;
               end
            end
            ST_RAMP_DOWN: begin
               if (bus.motor_on) begin
                  state_q <= ST_RAMP_UP;
                  rcnt_q  <= '0;
               end else if (tick_c) begin
                  rcnt_q <= '0;
                  if (duty_q != '0) begin
                     duty_q <= duty_q - ONE_V;
                  end
                  if (duty_q <= ONE_V) begin
                     state_q   <= ST_STOPPED;
                     ramping_q <= 1'b0;
                  end
               end else begin
                  rcnt_q <= rcnt_q + RDIV_W'(1);
               end
            end
            default: begin
               state_q    <= ST_STOPPED;
               duty_q     <= '0;
               rcnt_q     <= '0;
               ramping_q  <= 1'b0;
               at_speed_q <= 1'b0;
            end
         endcase
      end
   end

   pwm_gen #(
      .DUTY_W  (DUTY_W),
      .PWM_DIV (PWM_DIV)
   ) u_pwm (
      .clk     (clk),
      .reset   (reset),
      .duty_i  (duty_q),
      .clear_i (kill_c),
      .pwm_o   (bus.pwm_out)
   );

   assign bus.duty     = duty_q;
   assign bus.ramping  = ramping_q;
   assign bus.at_speed = at_speed_q;

endmodule

// File: doc/motor_soft_drive.md
# motor_soft_drive

Downstream stage of the motor control FSM: converts its `motor_on` level into a PWM gate signal with linear soft-start and soft-stop duty ramps. This limits inrush current at start-up and at each cooldown expiry. Sits between the control FSM and the motor driver pin; also exports the applied duty and ramp status for the display/LED logic.

## Interface
- `DUTY_W`, 8: duty and PWM counter width. `DUTY_MAX` = 2^DUTY_W − 1.
- `PWM_DIV`, 10: clk cycles per PWM counter step (≥1). PWM period = `PWM_DIV`·`DUTY_MAX` cycles.
- `RAMP_DIV`, 50000: clk cycles per duty step of ±1 during ramps (≥1).

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `motor_on`  in  1  run request from the control FSM (already synchronous to `clk`).
- `pwm_out`  out  1  registered PWM gate; high = drive motor.
- `duty`  out  DUTY_W  current target duty (ramp value).
- `ramping`  out  1  high in RAMP_UP or RAMP_DOWN.
- `at_speed`  out  1  high in RUNNING.

## Operation
- States: STOPPED, RAMP_UP, RUNNING, RAMP_DOWN.
- STOPPED: `duty`=0. `motor_on`=1 → RAMP_UP.
- RAMP_UP: on each ramp tick, `duty`+1.
  - When a tick makes `duty`=`DUTY_MAX` → RUNNING.
  - `motor_on`=0 → RAMP_DOWN, keeping the current `duty`.
- RUNNING: `duty`=`DUTY_MAX`. `motor_on`=0 → RAMP_DOWN.
- RAMP_DOWN: on each ramp tick, `duty`−1.
  - When a tick makes `duty`=0 → STOPPED.
  - `motor_on`=1 → RAMP_UP from the current `duty`.
- Ramp tick:
  - Ramp prescaler counts 0..`RAMP_DIV`−1 and ticks at `RAMP_DIV`−1.
  - Cleared to 0 on every state transition, so the first step always comes a full `RAMP_DIV` cycles after entry.
- Simultaneous events: a `motor_on` change takes priority over a ramp tick in the same cycle. The state changes and `duty` is not stepped.
- `duty` saturates and never wraps.
- PWM:
  - Counter `pcnt` steps 0..`DUTY_MAX`−1 once every `PWM_DIV` cycles, then wraps to 0.
  - A shadow register loads `duty` when `pcnt` wraps to 0 (period boundary). This gives glitch-free duty updates.
  - `pwm_out` = (`pcnt` < shadow), registered.
  - Shadow = 0 → `pwm_out` constantly low. Shadow = `DUTY_MAX` → constantly high.
- Reset values: state STOPPED; `duty`=0; shadow=0; `pcnt`=0; all prescalers 0; `pwm_out`=0; `ramping`=0; `at_speed`=0.
- Reset mid-ramp: immediate asynchronous return to the reset values; `pwm_out` drops without ramp-down.

## Timing
- `motor_on` sampled on the clk edge. State changes on that edge; `ramping`/`at_speed` are valid in the following cycle (1-cycle latency).
- First `duty` step: `RAMP_DIV` cycles after entering a ramp state.
- `duty` → `pwm_out`: takes effect at the next PWM period boundary, plus 1 cycle of output register. Worst case is one PWM period + 1 cycle.
- Full ramp 0→`DUTY_MAX`: `DUTY_MAX`·`RAMP_DIV` cycles. With defaults at 50 MHz, PWM ≈ 19.6 kHz and ramp ≈ 255 ms.

## Configuration
- `MOTOR_SOFT_ESTOP_EN` defined:
  - Adds input port `estop` (1 bit, synchronous to `clk`).
  - `estop`=1 in any state → STOPPED next edge. `duty`=0, shadow=0 and `pwm_out`=0 on that same edge, bypassing the period boundary.
  - The block then stays latched in STOPPED until both `estop`=0 and `motor_on`=0 are seen in one cycle. Only after that re-arm does a new `motor_on`=1 start RAMP_UP.
- Undefined: no `estop` port and no latch logic; behaviour exactly as above.

## Structure
- Shared package `motor_pkg`:
  - State enum/localparams (2-bit: STOPPED=0, RAMP_UP=1, RUNNING=2, RAMP_DOWN=3).
  - Default `DUTY_W`/`PWM_DIV`/`RAMP_DIV` constants.
- Sub-module `pwm_gen` holds the PWM counter, its prescaler, the shadow register and the compare/output register.
- Top level holds the FSM, the ramp prescaler and the `duty` register.

## Test plan
Bench parameters: `DUTY_W`=4 (`DUTY_MAX`=15), `PWM_DIV`=1, `RAMP_DIV`=4.
- Reset, `motor_on`=0 for 100 cycles → `pwm_out`=0, `duty`=0, `ramping`=0, `at_speed`=0 throughout.
- `motor_on`↑ and held → `ramping`=1 next cycle; `duty` reaches 1 after 4 cycles and 15 after 60 cycles, then `at_speed`=1; `pwm_out` constantly high from the next period boundary.
- From RUNNING, `motor_on`↓ → `duty` reaches 0 after 60 cycles, then STOPPED; `pwm_out` duty cycle in each 15-cycle period equals the shadow value / 15.
- `motor_on`↓ while RAMP_UP at `duty`=6 → RAMP_DOWN; `duty` goes 5,4,… with no wrap; re-assert at `duty`=3 → ramps up from 3.
- `motor_on` toggles in the same cycle as a ramp tick → state changes and `duty` is unchanged that cycle.
- `reset` pulsed asynchronously mid-RAMP_UP, between clock edges → all outputs 0 immediately. With `MOTOR_SOFT_ESTOP_EN`: `estop`=1 while RUNNING → `pwm_out`=0 on the next edge; restart requires `motor_on`=0 first.
